// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
//
// Shares one line-granular main memory between the instruction-side cache
// (client 0) and the data-side cache (client 1). One line request is latched
// at a time and presented to memory unchanged until the memory grants it.
// Read lines come back through per-client registers. Every transaction ends
// with a request-free cycle so the memory's delay counters can clear.
//
// Optional feature macro: ARB_FIXED_PRIO_EN
//   defined   : client 1 always wins a simultaneous request (no RR pointer)
//   undefined : round-robin, the client not served last wins a tie;
//               client 0 wins the first tie after reset
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   cN_addr                   client line address
//   cN_rd_req / cN_wr_req     line read / write request, held until cN_gnt
//   cN_wr_line                client write line
//   cN_rd_line                registered read line for client N
//   cN_gnt                    one-cycle completion pulse
//   mem_addr, mem_rd_req,
//   mem_wr_req, mem_wr_line   registered memory request
//   mem_rd_line, mem_gnt      memory response
//   busy                      high in every state except IDLE
//   owner                     client of the current or last transaction
//
// state | meaning
// IDLE  | no transaction; arbitrate pending client requests
// BUSY  | request driven to memory, waiting for mem_gnt
// HOLD  | read granted, memory line valid; capture it
// RESP  | pulse owner's gnt, memory requests low for one cycle

module mem_line_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_LEN-1:0]                 c0_addr,
    input  logic [ADDR_LEN-1:0]                 c1_addr,
    input  logic                                c0_rd_req,
    input  logic                                c1_rd_req,
    input  logic                                c0_wr_req,
    input  logic                                c1_wr_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    c0_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    c1_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    c0_rd_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    c1_rd_line,
    output logic                                c0_gnt,
    output logic                                c1_gnt,
    output logic [ADDR_LEN-1:0]                 mem_addr,
    output logic                                mem_rd_req,
    output logic                                mem_wr_req,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_rd_line,
    input  logic                                mem_gnt,
    output logic                                busy,
    output logic                                owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;

    logic pend0;
    logic pend1;
    logic sel;
    logic sel_rd;

`ifndef ARB_FIXED_PRIO_EN
    // Client that wins the next simultaneous request.
    logic rr_ptr;
`endif

    always_comb begin
        pend0 = c0_rd_req | c0_wr_req;
        pend1 = c1_rd_req | c1_wr_req;
`ifdef ARB_FIXED_PRIO_EN
        sel = pend1;
`else
        sel = (pend0 && pend1) ? rr_ptr : pend1;
`endif
        // rd_req takes precedence when a client raises both
        sel_rd = sel ? c1_rd_req : c0_rd_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_addr    <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_wr_line <= '0;
            c0_rd_line  <= '0;
            c1_rd_line  <= '0;
            c0_gnt      <= 1'b0;
            c1_gnt      <= 1'b0;
            busy        <= 1'b0;
            owner       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pend0 || pend1) begin
                        mem_addr    <= sel ? c1_addr : c0_addr;
                        mem_wr_line <= sel ? c1_wr_line : c0_wr_line;
                        mem_rd_req  <= sel_rd;
                        mem_wr_req  <= ~sel_rd;
                        owner       <= sel;
                        busy        <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_gnt) begin
                        if (mem_rd_req) begin
                            state <= HOLD;
                        end else begin
                            mem_wr_req <= 1'b0;
                            c0_gnt     <= ~owner;
                            c1_gnt     <= owner;
                            state      <= RESP;
                        end
                    end
                end
                HOLD: begin
                    if (owner) begin
                        c1_rd_line <= mem_rd_line;
                    end else begin
                        c0_rd_line <= mem_rd_line;
                    end
                    mem_rd_req <= 1'b0;
                    c0_gnt     <= ~owner;
                    c1_gnt     <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    c0_gnt <= 1'b0;
                    c1_gnt <= 1'b0;
                    busy   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr <= ~owner;
`endif
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter
//
// Directed bench for mem_line_arbiter with a behavioural main_mem model
// (fixed grant latency, read line valid only in the cycle after mem_gnt).
// Expected grants are queued per client when a request is driven and
// checked when the DUT pulses cN_gnt.

module tb_mem_line_arbiter;

    localparam int LAT = 2;

    typedef logic [7:0][31:0] line_t;
    typedef struct {
        bit         rd;
        logic [7:0] addr;
        line_t      data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] c0_addr, c1_addr;
    logic       c0_rd_req, c1_rd_req, c0_wr_req, c1_wr_req;
    line_t      c0_wr_line, c1_wr_line, c0_rd_line, c1_rd_line;
    logic       c0_gnt, c1_gnt;
    logic [7:0] mem_addr;
    logic       mem_rd_req, mem_wr_req;
    line_t      mem_wr_line, mem_rd_line;
    logic       mem_gnt;
    logic       busy, owner;

    mem_line_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .c0_addr     (c0_addr),
        .c1_addr     (c1_addr),
        .c0_rd_req   (c0_rd_req),
        .c1_rd_req   (c1_rd_req),
        .c0_wr_req   (c0_wr_req),
        .c1_wr_req   (c1_wr_req),
        .c0_wr_line  (c0_wr_line),
        .c1_wr_line  (c1_wr_line),
        .c0_rd_line  (c0_rd_line),
        .c1_rd_line  (c1_rd_line),
        .c0_gnt      (c0_gnt),
        .c1_gnt      (c1_gnt),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    int    n_checks;
    int    n_fail;
    int    cyc;
    int    gnt_cyc;
    exp_t  q0[$];
    exp_t  q1[$];
    bit    grant_log[$];
    line_t ref_mem [256];
    line_t last_rd [2];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t pat(input int a);
        line_t l;
        for (int w = 0; w < 8; w++) l[w] = {8'hA5, 8'(a), 8'h3C, 8'(w)};
        return l;
    endfunction

    // ---------------- main_mem model ----------------
    line_t mem_arr [256];
    bit    mem_init;
    int    mcnt;
    logic  rd_valid;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= pat(i);
            mem_init <= 1'b1;
        end else if (mem_gnt && mem_wr_req) begin
            mem_arr[mem_addr] <= mem_wr_line;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt     <= 0;
            mem_gnt  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            mem_gnt  <= 1'b0;
            rd_valid <= mem_gnt & mem_rd_req;
            if (mem_rd_req || mem_wr_req) begin
                if (mcnt == LAT) mem_gnt <= 1'b1;
                if (mcnt <= LAT) mcnt <= mcnt + 1;
            end else begin
                mcnt <= 0;
            end
        end
    end

    assign mem_rd_line = rd_valid ? mem_arr[mem_addr] : {8{32'hDEADBEEF}};

    always @(posedge clk) cyc++;

    // ---------------- monitor / scoreboard ----------------
    logic       prev_busy;
    logic [7:0] prev_addr;
    line_t      prev_wline;

    task automatic check_grant(input bit c);
        exp_t e;
        bit   has;
        has = c ? (q1.size() != 0) : (q0.size() != 0);
        chk($sformatf("c%0d_gnt_expected", c), has, 1);
        if (has) begin
            e = c ? q1.pop_front() : q0.pop_front();
            chk($sformatf("c%0d_owner", c), owner, c);
            chk($sformatf("c%0d_mem_addr", c), mem_addr, e.addr);
            chk($sformatf("c%0d_resp_no_req", c), {mem_rd_req, mem_wr_req}, 2'b00);
            chk($sformatf("c%0d_latency", c), cyc - gnt_cyc, e.rd ? 2 : 1);
            if (e.rd) begin
                chk($sformatf("c%0d_rd_line", c), c ? c1_rd_line : c0_rd_line, e.data);
                last_rd[c] = e.data;
            end
            grant_log.push_back(c);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_gnt) gnt_cyc = cyc;
            if (busy && prev_busy) begin
                chk("addr_stable", mem_addr, prev_addr);
                chk("wr_line_stable", mem_wr_line, prev_wline);
            end
            if (c0_gnt || c1_gnt) begin
                chk("gnt_exclusive", c0_gnt & c1_gnt, 1'b0);
                if (c0_gnt) check_grant(1'b0);
                if (c1_gnt) check_grant(1'b1);
            end
            prev_busy  = busy;
            prev_addr  = mem_addr;
            prev_wline = mem_wr_line;
        end else begin
            prev_busy = 1'b0;
        end
    end

    // ---------------- client driver ----------------
    task automatic txn(input bit c, input bit rd, input logic [7:0] a, input line_t d,
                       input bit also_wr);
        exp_t e;
        int   n;
        e.rd   = rd;
        e.addr = a;
        e.data = rd ? ref_mem[a] : d;
        if (!rd) ref_mem[a] = d;
        if (c) q1.push_back(e); else q0.push_back(e);
        if (c) begin
            c1_addr = a; c1_rd_req = rd; c1_wr_req = !rd | also_wr; c1_wr_line = d;
        end else begin
            c0_addr = a; c0_rd_req = rd; c0_wr_req = !rd | also_wr; c0_wr_line = d;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(c ? c1_gnt : c0_gnt) && n < 300);
        if (n >= 300) chk($sformatf("c%0d_timeout_addr_%0h", c, a), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        if (c) begin
            c1_rd_req = 1'b0; c1_wr_req = 1'b0;
        end else begin
            c0_rd_req = 1'b0; c0_wr_req = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int    n;
        bit    exp_first;
        line_t d;

        c0_addr = '0; c1_addr = '0;
        c0_rd_req = 0; c1_rd_req = 0; c0_wr_req = 0; c1_wr_req = 0;
        c0_wr_line = '0; c1_wr_line = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        last_rd[0] = '0;
        last_rd[1] = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_rd_req", mem_rd_req, 1'b0);
        chk("rst_mem_wr_req", mem_wr_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wr_line", mem_wr_line, '0);
        chk("rst_gnt", {c0_gnt, c1_gnt}, 2'b00);
        chk("rst_busy_owner", {busy, owner}, 2'b00);
        chk("rst_c0_rd_line", c0_rd_line, '0);
        chk("rst_c1_rd_line", c1_rd_line, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // c0 read alone; address retained when idle
        txn(1'b0, 1'b1, 8'h12, '0, 1'b0);
        @(negedge clk);
        chk("idle_addr_hold", mem_addr, 8'h12);
        chk("idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // rd and wr both raised is a read
        txn(1'b0, 1'b1, 8'h33, {8{32'h0BADF00D}}, 1'b1);

        // c1 write then read back
        for (int w = 0; w < 8; w++) d[w] = 32'h100 + w;
        txn(1'b1, 1'b0, 8'h05, d, 1'b0);
        txn(1'b1, 1'b1, 8'h05, '0, 1'b0);

        // simultaneous reads
`ifdef ARB_FIXED_PRIO_EN
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        n = grant_log.size();
        fork
            txn(1'b0, 1'b1, 8'h01, '0, 1'b0);
            txn(1'b1, 1'b1, 8'h02, '0, 1'b0);
        join
        chk("tie1_first", grant_log[n], exp_first);
        chk("tie1_second", grant_log[n+1], !exp_first);

        // after serving c0 last, a tie goes to c1 in both builds
        txn(1'b0, 1'b1, 8'h04, '0, 1'b0);
        n = grant_log.size();
        fork
            txn(1'b0, 1'b1, 8'h06, '0, 1'b0);
            txn(1'b1, 1'b1, 8'h07, '0, 1'b0);
        join
        chk("tie2_first", grant_log[n], 1'b1);
        chk("tie2_second", grant_log[n+1], 1'b0);

        // reset during BUSY of a c0 read
        @(posedge clk);
        #1;
        c0_addr = 8'h20;
        c0_rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {busy, mem_rd_req}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_mem_rd_req", mem_rd_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_c0_gnt", c0_gnt, 1'b0);
        c0_rd_req = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_gnt", {c0_gnt, c1_gnt}, 2'b00);
        @(posedge clk);
        #1;
        txn(1'b0, 1'b1, 8'h20, '0, 1'b0);

        // c1 write arrives while c0 read is in flight
        for (int w = 0; w < 8; w++) d[w] = 32'hCAFE0000 + w;
        n = grant_log.size();
        fork
            txn(1'b0, 1'b1, 8'h03, '0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                txn(1'b1, 1'b0, 8'h40, d, 1'b0);
            end
        join
        chk("mid_owner_first", grant_log[n], 1'b0);
        chk("mid_owner_second", grant_log[n+1], 1'b1);
        chk("mid_c0_rd_line_kept", c0_rd_line, ref_mem[8'h03]);
        chk("mid_c1_rd_line_kept", c1_rd_line, last_rd[1]);
        txn(1'b0, 1'b1, 8'h40, '0, 1'b0);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
